// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and defaults for the program-counter sequencer.
//   pc_seq_state_e : sequencer FSM states (BOOT, RUN, REDIR, HOLD)
//   pc_seq_src_e   : redirect source codes (NONE, JAL, BR, TRAP)
//   DEFAULT_RESET_VECTOR / DEFAULT_TRAP_VECTOR : default fetch vectors
//   CNT_W          : width of the flush-bubble counter (FLUSH_CYCLES <= 4)
// Optional feature macro used by the slice: PC_SEQ_MISALIGN_TRAP_EN.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_REDIR = 2'd2,
    ST_HOLD  = 2'd3
  } pc_seq_state_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_JAL  = 2'd1,
    SRC_BR   = 2'd2,
    SRC_TRAP = 2'd3
  } pc_seq_src_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
  localparam int          CNT_W                = 3;

  // Branches and traps are resolved in EX, so the instruction already in
  // ID/EX is wrong-path; a jump is decoded in ID, so ID/EX is still valid.
  function automatic logic needs_id_ex_flush(input pc_seq_src_e src);
    return (src == SRC_BR) || (src == SRC_TRAP);
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// pc_redirect_arb: combinational fixed-priority next-PC redirect arbiter.
// Priority: pending trap / trap_req > br_taken > jal_valid.
// Ports:
//   trap_pend, trap_req      : trap requests (pending flag and live request)
//   br_taken, br_target      : EX branch redirect
//   jal_valid, jal_target    : ID jump redirect
//   grant_src                : winning source (SRC_NONE when idle)
//   grant_target             : winning target address
//   grant_misalign           : winning BR/JAL target was misaligned and trapped
// Macro PC_SEQ_MISALIGN_TRAP_EN: misaligned BR/JAL targets become a trap to
// TRAP_VECTOR; otherwise target bits [1:0] are cleared.
module pc_redirect_arb
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic          trap_pend,
  input  logic          trap_req,
  input  logic          br_taken,
  input  logic [31:0]   br_target,
  input  logic          jal_valid,
  input  logic [31:0]   jal_target,
  output pc_seq_src_e   grant_src,
  output logic [31:0]   grant_target,
  output logic          grant_misalign
);

  pc_seq_src_e sel_src;
  logic [31:0] sel_target;

  always_comb begin
    sel_src    = SRC_NONE;
    sel_target = '0;
    if (trap_pend || trap_req) begin
      sel_src    = SRC_TRAP;
      sel_target = TRAP_VECTOR;
    end else if (br_taken) begin
      sel_src    = SRC_BR;
      sel_target = br_target;
    end else if (jal_valid) begin
      sel_src    = SRC_JAL;
      sel_target = jal_target;
    end
  end

  always_comb begin
    grant_src      = sel_src;
    grant_target   = sel_target;
    grant_misalign = 1'b0;
    if ((sel_src == SRC_BR) || (sel_src == SRC_JAL)) begin
`ifdef PC_SEQ_MISALIGN_TRAP_EN
      if (sel_target[1:0] != 2'b00) begin
        grant_src      = SRC_TRAP;
        grant_target   = TRAP_VECTOR;
        grant_misalign = 1'b1;
      end
`else
      grant_target[1:0] = 2'b00;
`endif
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the 5-stage pipeline.
// Arbitrates trap / branch / jump redirects, merges hazard and imem stalls,
// inserts FLUSH_CYCLES bubbles per redirect and loads the boot vector.
// Ports:
//   clk, rst                : clock, synchronous active-high reset
//   hz_stall, imem_ready    : load-use stall, imem accepts fetch
//   br_taken, br_target     : EX branch redirect request
//   jal_valid, jal_target   : ID jump redirect request
//   trap_req                : trap request
//   pc_stall, pc_write, pc_src : PC controls
//   flush_if_id, flush_id_ex   : pipeline register kills
//   fetch_valid             : current fetch is on the correct path
//   misalign                : pulse in REDIR for a trapped misaligned target
//   state_dbg               : current FSM state (pc_seq_state_e encoding)
// Macro PC_SEQ_MISALIGN_TRAP_EN enables misaligned-target trapping.
//
// Handshake: there is no valid/ready pair; requests are level-sampled
// each rising edge in RUN and either win arbitration or are dropped.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
  parameter int          FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz_stall,
  input  logic        imem_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        jal_valid,
  input  logic [31:0] jal_target,
  input  logic        trap_req,
  output logic        pc_stall,
  output logic        pc_write,
  output logic [31:0] pc_src,
  output logic        flush_if_id,
  output logic        flush_id_ex,
  output logic        fetch_valid,
  output logic        misalign,
  output logic [1:0]  state_dbg
);

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  pc_seq_state_e    state_q, state_d;
  pc_seq_src_e      src_q;
  logic [31:0]      target_q;
  logic             mis_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_pend_q, trap_pend_d;
  logic             in_reset_q;
  logic             capture;

  pc_seq_src_e      grant_src;
  logic [31:0]      grant_target;
  logic             grant_misalign;

  pc_redirect_arb #(
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_arb (
    .trap_pend      (trap_pend_q),
    .trap_req       (trap_req),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .jal_valid      (jal_valid),
    .jal_target     (jal_target),
    .grant_src      (grant_src),
    .grant_target   (grant_target),
    .grant_misalign (grant_misalign)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    trap_pend_d = trap_pend_q;
    capture     = 1'b0;
    pc_stall    = 1'b0;
    pc_write    = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    fetch_valid = 1'b0;
    misalign    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        // in_reset_q keeps BOOT outputs quiet while rst is still held, so
        // the boot-vector load happens in the first cycle after release.
        if (in_reset_q) begin
          pc_stall = 1'b1;
        end else begin
          pc_write = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        fetch_valid = 1'b1;
        pc_stall    = hz_stall | ~imem_ready;
        // Redirects win over stalls: the target is captured regardless.
        if (grant_src != SRC_NONE) begin
          capture     = 1'b1;
          trap_pend_d = 1'b0;
          state_d     = ST_REDIR;
        end
      end
      ST_REDIR: begin
        pc_write    = 1'b1;
        flush_if_id = 1'b1;
        flush_id_ex = needs_id_ex_flush(src_q);
        misalign    = mis_q;
        trap_pend_d = trap_pend_q | trap_req;
        cnt_d       = FLUSH_LOAD;
        state_d     = (FLUSH_LOAD == '0) ? ST_RUN : ST_HOLD;
      end
      ST_HOLD: begin
        pc_stall    = 1'b1;
        flush_if_id = 1'b1;
        trap_pend_d = trap_pend_q | trap_req;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q <= 1) state_d = ST_RUN;
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_BOOT;
      in_reset_q  <= 1'b1;
      trap_pend_q <= 1'b0;
      target_q    <= RESET_VECTOR;
      src_q       <= SRC_NONE;
      mis_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_reset_q  <= 1'b0;
      trap_pend_q <= trap_pend_d;
      cnt_q       <= cnt_d;
      if (capture) begin
        target_q <= grant_target;
        src_q    <= grant_src;
        mis_q    <= grant_misalign;
      end
    end
  end

  assign pc_src    = target_q;
  assign state_dbg = state_q;

endmodule
